// File: rtl/turfio_wb_pkg.sv
// Shared types and constants for the TURFIO wishbone arbitration path.
package turfio_wb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int WB_AW = 22;
    localparam int WB_DW = 32;

    // Master slot assignment on the shared slave path
    localparam int GTP = 0;
    localparam int CTL = 1;
    localparam int DBG = 2;
    localparam int SER = 3;

endpackage

// File: rtl/turfio_rr_pick.sv
// Combinational round-robin selector: first requester strictly after 'last', with wrap.
module turfio_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from last+1 upward; the first hit latches and masks later candidates
    always_comb begin
        int  k;
        logic hit;
        k      = 0;
        hit    = 1'b0;
        onehot = {N{1'b0}};
        idx    = {IW{1'b0}};
        valid  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            k         = (int'(last) + i) % N;
            hit       = req[k] & ~valid;
            onehot[k] = onehot[k] | hit;
            idx       = hit ? IW'(k) : idx;
            valid     = valid | hit;
        end
    end

endmodule

// File: rtl/turfio_wb_arbiter.sv
// Round-robin wishbone arbiter for the shared TURFIO slave path.
// Optional stall watchdog enabled by defining TURFIO_WB_ARB_TIMEOUT_EN.
module turfio_wb_arbiter
    import turfio_wb_pkg::*;
#(
    parameter int NMASTER        = 4,
    parameter int ADDRESS_WIDTH  = WB_AW,
    parameter int DATA_WIDTH     = WB_DW,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic [NMASTER-1:0]                  m_cyc_i,
    input  logic [NMASTER-1:0]                  m_stb_i,
    input  logic [NMASTER-1:0]                  m_we_i,
    input  logic [NMASTER*ADDRESS_WIDTH-1:0]    m_adr_i,
    input  logic [NMASTER*DATA_WIDTH-1:0]       m_dat_i,
    input  logic [NMASTER*(DATA_WIDTH/8)-1:0]   m_sel_i,
    output logic [NMASTER-1:0]                  m_ack_o,
    output logic [NMASTER-1:0]                  m_err_o,
    output logic [NMASTER-1:0]                  m_rty_o,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic                                s_cyc_o,
    output logic                                s_stb_o,
    output logic                                s_we_o,
    output logic [ADDRESS_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [DATA_WIDTH/8-1:0]             s_sel_o,
    input  logic                                s_ack_i,
    input  logic                                s_err_i,
    input  logic                                s_rty_i,
    input  logic [DATA_WIDTH-1:0]               s_dat_i,
    output logic [NMASTER-1:0]                  grant_o,
    output logic                                timeout_o
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(NMASTER);

    arb_state_t         state_r, state_s;
    logic [NMASTER-1:0] grant_r, grant_s;
    logic [IW-1:0]      last_r, last_s;
    logic [NMASTER-1:0] pick_onehot_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_valid_s;

    turfio_rr_pick #(
        .N  (NMASTER),
        .IW (IW)
    ) u_pick (
        .req    (m_cyc_i),
        .last   (last_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Arbiter state, grant and round-robin pointer registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            grant_r <= {NMASTER{1'b0}};
            last_r  <= IW'(NMASTER - 1);
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            last_r  <= last_s;
        end
    end

    // Next-state: grant on any CYC, hold until the owner drops CYC; leaving GRANT forces a dead IDLE cycle
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s = GRANT;
                    grant_s = pick_onehot_s;
                    last_s  = pick_idx_s;
                end else begin
                    state_s = IDLE;
                    grant_s = {NMASTER{1'b0}};
                end
            end
            GRANT: begin
                if (!m_cyc_i[last_r]) begin
                    state_s = IDLE;
                    grant_s = {NMASTER{1'b0}};
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {NMASTER{1'b0}};
            end
        endcase
    end

    // AND-OR mux of the granted master onto the slave port; all zero when nothing is granted
    always_comb begin
        s_cyc_o = |(m_cyc_i & grant_r);
        s_stb_o = |(m_stb_i & grant_r);
        s_we_o  = |(m_we_i  & grant_r);
        s_adr_o = {AW{1'b0}};
        s_dat_o = {DW{1'b0}};
        s_sel_o = {SW{1'b0}};
        for (int k = 0; k < NMASTER; k++) begin
            s_adr_o = s_adr_o | (m_adr_i[k*AW +: AW] & {AW{grant_r[k]}});
            s_dat_o = s_dat_o | (m_dat_i[k*DW +: DW] & {DW{grant_r[k]}});
            s_sel_o = s_sel_o | (m_sel_i[k*SW +: SW] & {SW{grant_r[k]}});
        end
    end

    assign grant_o = grant_r;
    assign m_dat_o = s_dat_i;

`ifdef TURFIO_WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_r;
    logic        timeout_r;
    logic        to_hit_s;
    logic        slv_resp_s;

    assign slv_resp_s = s_ack_i | s_err_i | s_rty_i;
    assign to_hit_s   = s_stb_o & (to_cnt_r == TO_LAST);

    // Stall watchdog: counts unanswered STB cycles, raises a sticky flag on expiry
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt_r  <= 16'd0;
            timeout_r <= 1'b0;
        end else if (to_hit_s) begin
            to_cnt_r  <= 16'd0;
            timeout_r <= 1'b1;
        end else if (!s_stb_o || slv_resp_s) begin
            to_cnt_r  <= 16'd0;
            timeout_r <= timeout_r;
        end else begin
            to_cnt_r  <= to_cnt_r + 16'd1;
            timeout_r <= timeout_r;
        end
    end

    // On expiry the forced err replaces whatever the slave drives that cycle
    assign m_ack_o   = grant_r & {NMASTER{s_ack_i & ~to_hit_s}};
    assign m_err_o   = grant_r & {NMASTER{s_err_i | to_hit_s}};
    assign m_rty_o   = grant_r & {NMASTER{s_rty_i & ~to_hit_s}};
    assign timeout_o = timeout_r;
`else
    logic unused_cfg_s;

    assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
    assign m_ack_o      = grant_r & {NMASTER{s_ack_i}};
    assign m_err_o      = grant_r & {NMASTER{s_err_i}};
    assign m_rty_o      = grant_r & {NMASTER{s_rty_i}};
    assign timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_turfio_wb_arbiter.sv
// Directed scoreboard bench for turfio_wb_arbiter (both TURFIO_WB_ARB_TIMEOUT_EN settings).
module tb_turfio_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int SW = 4;
`ifdef TURFIO_WB_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            clk = 1'b0;
    logic            wb_rst_i;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [DW-1:0]   s_dat_i;
    logic [N-1:0]    grant_o;
    logic            timeout_o;

    always #10 clk = ~clk;

    turfio_wb_arbiter #(
        .NMASTER        (N),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_sel_i   (m_sel),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_rty_o   (m_rty_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_rty_i   (s_rty_i),
        .s_dat_i   (s_dat_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    typedef struct {
        int            m;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } txn_t;

    txn_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_m(input int k, input logic c, input logic s, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] se);
        m_cyc[k]             = c;
        m_stb[k]             = s;
        m_we[k]              = we;
        m_adr[k*AW +: AW]    = a;
        m_dat[k*DW +: DW]    = d;
        m_sel[k*SW +: SW]    = se;
    endtask

    // Drive a master access and record what the slave side must see for it
    task automatic req(input int k, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] se);
        txn_t t;
        drive_m(k, 1'b1, 1'b1, we, a, d, se);
        t.m = k; t.we = we; t.adr = a; t.dat = d; t.sel = se;
        sbq.push_back(t);
    endtask

    task automatic do_reset();
        chk("sb_empty_before_reset", 64'(sbq.size()), 64'd0);
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
    endtask

    // Called at a negedge: wait for STB, check against scoreboard, respond (0 ack,1 err,2 rty)
    task automatic serve(input int m, input int resp, input bit drop, output int waits);
        int            idx;
        txn_t          t;
        logic [DW-1:0] rd;
        logic [N-1:0]  one, exp_g, zero;
        one   = {{(N-1){1'b0}}, 1'b1};
        zero  = {N{1'b0}};
        exp_g = one << m;
        waits = 0;
        while (!s_stb_o && waits < 40) begin
            tick();
            smp();
            waits++;
        end
        chk("stb_seen", 64'(s_stb_o), 64'd1);
        chk("grant", 64'(grant_o), 64'(exp_g));
        chk("s_cyc", 64'(s_cyc_o), 64'd1);
        idx = -1;
        foreach (sbq[i]) begin
            if (idx < 0 && sbq[i].m == m) idx = i;
        end
        chk("sb_has_txn", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
            t = sbq[idx];
            sbq.delete(idx);
            chk("s_we", 64'(s_we_o), 64'(t.we));
            chk("s_adr", 64'(s_adr_o), 64'(t.adr));
            chk("s_dat", 64'(s_dat_o), 64'(t.dat));
            chk("s_sel", 64'(s_sel_o), 64'(t.sel));
        end
        rd      = $urandom;
        s_dat_i = rd;
        s_ack_i = (resp == 0);
        s_err_i = (resp == 1);
        s_rty_i = (resp == 2);
        if (drop) begin
            m_cyc[m] = 1'b0;
            m_stb[m] = 1'b0;
        end
        #1;
        chk("m_ack", 64'(m_ack_o), 64'(resp == 0 ? exp_g : zero));
        chk("m_err", 64'(m_err_o), 64'(resp == 1 ? exp_g : zero));
        chk("m_rty", 64'(m_rty_o), 64'(resp == 2 ? exp_g : zero));
        chk("m_dat", 64'(m_dat_o), 64'(rd));
        tick();
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
    endtask

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;
        wb_rst_i = 1'b1;
        tick();
        tick();
        smp();
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_s_stb", 64'(s_stb_o), 64'd0);
        chk("rst_ack", 64'(m_ack_o), 64'd0);
        chk("rst_err", 64'(m_err_o), 64'd0);
        chk("rst_rty", 64'(m_rty_o), 64'd0);
        chk("rst_timeout", 64'(timeout_o), 64'd0);
        tick();
        wb_rst_i = 1'b0;

        // 1: single requester (dbg) write, one-cycle grant latency
        req(2, 1'b1, 22'h001004, 32'hDEADBEEF, 4'hF);
        smp();
        chk("t1_no_cyc_yet", 64'(s_cyc_o), 64'd0);
        tick();
        smp();
        chk("t1_cyc_after_edge", 64'(s_cyc_o), 64'd1);
        serve(2, 0, 1'b1, w);
        chk("t1_wait", 64'(w), 64'd0);
        smp();
        chk("t1_release", 64'(grant_o), 64'd0);

        // 2: all four request from reset, two rounds, one dead cycle between grants
        do_reset();
        for (int k = 0; k < N; k++) req(k, 1'b1, 22'(24'h000100 + 24'(k)), 32'h1000_0000 + 32'(k), 4'h3);
        tick();
        smp();
        serve(0, 0, 1'b1, w);
        chk("t2_first_wait", 64'(w), 64'd0);
        for (int k = 1; k < N; k++) begin
            smp();
            chk("t2_dead", 64'(grant_o), 64'd0);
            serve(k, 0, 1'b1, w);
            chk("t2_gap", 64'(w), 64'd1);
        end
        for (int k = 0; k < N; k++) req(k, 1'b0, 22'(24'h000200 + 24'(k)), 32'h2000_0000 + 32'(k), 4'hC);
        for (int k = 0; k < N; k++) begin
            smp();
            chk("t2b_dead", 64'(grant_o), 64'd0);
            serve(k, 0, 1'b1, w);
            chk("t2b_gap", 64'(w), 64'd1);
        end

        // 3: ctl bursts three accesses while ser waits; no switch until ctl drops
        do_reset();
        req(1, 1'b1, 22'h000010, 32'hA0A0A0A0, 4'hF);
        req(3, 1'b0, 22'h003000, 32'h33333333, 4'h1);
        tick();
        smp();
        serve(1, 0, 1'b0, w);
        req(1, 1'b0, 22'h000014, 32'hA1A1A1A1, 4'h2);
        smp();
        serve(1, 2, 1'b0, w);
        chk("t3_burst2_wait", 64'(w), 64'd0);
        req(1, 1'b1, 22'h000018, 32'hA2A2A2A2, 4'h4);
        smp();
        serve(1, 1, 1'b1, w);
        chk("t3_burst3_wait", 64'(w), 64'd0);
        smp();
        chk("t3_dead", 64'(grant_o), 64'd0);
        serve(3, 0, 1'b1, w);
        chk("t3_ser_gap", 64'(w), 64'd1);

        // 4: ack coincident with cyc drop, next grant two edges later
        do_reset();
        req(0, 1'b1, 22'h000040, 32'h0BADF00D, 4'hF);
        req(2, 1'b1, 22'h000044, 32'hFEEDFACE, 4'hF);
        tick();
        smp();
        serve(0, 0, 1'b1, w);
        smp();
        chk("t4_edge1_idle", 64'(grant_o), 64'd0);
        tick();
        smp();
        chk("t4_edge2_grant", 64'(grant_o), 64'h4);
        serve(2, 0, 1'b1, w);
        chk("t4_wait", 64'(w), 64'd0);

        // 5: reset mid-burst of gtp
        do_reset();
        drive_m(0, 1'b1, 1'b1, 1'b1, 22'h000080, 32'h55AA55AA, 4'hF);
        tick();
        smp();
        chk("t5_cyc_before", 64'(s_cyc_o), 64'd1);
        wb_rst_i = 1'b1;
        tick();
        s_ack_i = 1'b1;
        smp();
        chk("t5_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("t5_grant", 64'(grant_o), 64'd0);
        chk("t5_no_ack", 64'(m_ack_o), 64'd0);
        tick();
        wb_rst_i = 1'b0;
        smp();
        chk("t5_no_ack_after", 64'(m_ack_o), 64'd0);
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        s_ack_i  = 1'b0;
        tick();

        // 6: slave never answers
        do_reset();
        req(2, 1'b0, 22'h000100, 32'h0, 4'hF);
        tick();
`ifdef TURFIO_WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            smp();
            chk("t6_err_pulse", 64'(m_err_o), (i == TO) ? 64'h4 : 64'h0);
            chk("t6_ack_none", 64'(m_ack_o), 64'h0);
            chk("t6_timeout_pre", 64'(timeout_o), 64'd0);
            tick();
        end
        smp();
        chk("t6_timeout_set", 64'(timeout_o), 64'd1);
        chk("t6_err_one_cycle", 64'(m_err_o), 64'd0);
`else
        for (int i = 1; i <= 20; i++) begin
            smp();
            chk("t6_stalled", 64'(s_stb_o), 64'd1);
            chk("t6_no_err", 64'(m_err_o), 64'd0);
            chk("t6_timeout_zero", 64'(timeout_o), 64'd0);
            tick();
        end
        smp();
`endif
        serve(2, 0, 1'b1, w);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
